// File: rtl/bcast_fanout.sv
// Collective-tree broadcast fan-out: one accepted flit becomes one rewritten copy
// per selected torus neighbour (plus an optional local copy), in ascending port order.
module bcast_fanout #(
  parameter int          FlitWidth = 82,
  parameter logic [2:0]  rank_x    = 3'b0,
  parameter logic [2:0]  rank_y    = 3'b0,
  parameter logic [2:0]  rank_z    = 3'b0,
  parameter int          DimSize   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FlitWidth-1:0] in_flit,
  input  logic [6:0]           in_mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [FlitWidth-1:0] out_flit,
  output logic [2:0]           out_port,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 done,
  output logic                 busy
);

  localparam logic [2:0] DMAX = 3'(DimSize - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [62:0] hold;
  logic [6:0]  pend;
  logic [6:0]  rem;
  logic [2:0]  first_idx, next_idx;
  logic        accept, hs;
  logic        unused_bits;

  // Routing/header fields of the incoming flit are replaced in every copy.
  assign unused_bits = ^in_flit[80:63];

  function automatic logic [2:0] lowest(input logic [6:0] m);
    lowest = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  function automatic logic [2:0] step(input logic [2:0] c, input logic up);
    if (up) step = (c == DMAX) ? 3'd0 : c + 3'd1;
    else    step = (c == 3'd0) ? DMAX : c - 3'd1;
  endfunction

  function automatic logic [FlitWidth-1:0] build_copy(input logic [62:0] h, input logic [2:0] port);
    logic [2:0] dx, dy, dz;
    dx = rank_x;
    dy = rank_y;
    dz = rank_z;
    case (port)
      3'd0:    dx = step(rank_x, 1'b1);
      3'd1:    dx = step(rank_x, 1'b0);
      3'd2:    dy = step(rank_y, 1'b1);
      3'd3:    dy = step(rank_y, 1'b0);
      3'd4:    dz = step(rank_z, 1'b1);
      3'd5:    dz = step(rank_z, 1'b0);
      default: ;
    endcase
    build_copy = {1'b1, dz, dy, dx, rank_z, rank_y, rank_x, h};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    accept    = in_valid && in_ready;
    hs        = out_valid && out_ready;
    // out_port doubles as the index of the copy currently on offer
    rem       = pend & ~(7'd1 << out_port);
    first_idx = lowest(in_mask);
    next_idx  = lowest(rem);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (accept && in_flit[81] && (in_mask != 7'd0)) state_d = SEND;
      SEND:    if (hs && (rem == 7'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold     <= '0;
      pend     <= '0;
      out_flit <= '0;
      out_port <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        hold <= in_flit[62:0];
        pend <= in_mask;
        if (in_flit[81]) begin
          if (in_mask == 7'd0) begin
            done <= 1'b1;
          end else begin
            out_flit <= build_copy(in_flit[62:0], first_idx);
            out_port <= first_idx;
          end
        end
      end else if (hs) begin
        pend <= rem;
        if (rem != 7'd0) begin
          out_flit <= build_copy(hold, next_idx);
          out_port <= next_idx;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcast_fanout.sv
// Directed bench for bcast_fanout: three instances with different ranks/ring sizes share stimulus.
module tb_bcast_fanout;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [81:0] in_flit = '0;
  logic [6:0]  in_mask = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, done0, busy0;
  logic [81:0] out_flit0;
  logic [2:0]  out_port0;
  logic        in_ready1, out_valid1, done1, busy1;
  logic [81:0] out_flit1;
  logic [2:0]  out_port1;
  logic        in_ready2, out_valid2, done2, busy2;
  logic [81:0] out_flit2;
  logic [2:0]  out_port2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcast_fanout #(.FlitWidth(82), .rank_x(3'd2), .rank_y(3'd3), .rank_z(3'd7), .DimSize(8)) u0 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_mask(in_mask), .in_valid(in_valid),
    .in_ready(in_ready0), .out_flit(out_flit0), .out_port(out_port0), .out_valid(out_valid0),
    .out_ready(out_ready), .done(done0), .busy(busy0));

  bcast_fanout #(.FlitWidth(82), .rank_x(3'd7), .rank_y(3'd0), .rank_z(3'd5), .DimSize(8)) u1 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_mask(in_mask), .in_valid(in_valid),
    .in_ready(in_ready1), .out_flit(out_flit1), .out_port(out_port1), .out_valid(out_valid1),
    .out_ready(out_ready), .done(done1), .busy(busy1));

  bcast_fanout #(.FlitWidth(82), .rank_x(3'd3), .rank_y(3'd1), .rank_z(3'd0), .DimSize(4)) u2 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_mask(in_mask), .in_valid(in_valid),
    .in_ready(in_ready2), .out_flit(out_flit2), .out_port(out_port2), .out_valid(out_valid2),
    .out_ready(out_ready), .done(done2), .busy(busy2));

  typedef struct {
    logic        v81;
    logic [6:0]  mask;
    logic [31:0] payload;
    int          stall;
    logic [6:0]  exp_ports;
    logic        exp_done;
  } vec_t;

  vec_t        vecs [13];
  logic [8:0]  dst0 [7];
  logic [8:0]  dst1 [7];
  logic [8:0]  dst2 [7];

  task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [81:0] mk_flit(input logic v, input logic [31:0] pl);
    return {v, 9'h155, 9'h0AA, 9'd77, 8'h5C, 8'hA3, 2'b10, 4'h9, pl};
  endfunction

  task automatic check_copy(input int p, input logic [81:0] f);
    chk("out_valid", 82'(out_valid0), 82'd1);
    chk("out_port", 82'(out_port0), 82'(p));
    chk("out_flit", out_flit0, {1'b1, dst0[p], 3'd7, 3'd3, 3'd2, f[62:0]});
    chk("dst_u1", 82'(out_flit1[80:72]), 82'(dst1[p]));
    chk("dst_u2", 82'(out_flit2[80:72]), 82'(dst2[p]));
    chk("in_ready_send", 82'(in_ready0), 82'd0);
    chk("busy_send", 82'(busy0), 82'd1);
    chk("done_during_copy", 82'(done0), 82'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [81:0] f;
    int n;
    logic first;
    f = mk_flit(v.v81, v.payload);
    in_flit   = f;
    in_mask   = v.mask;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("in_ready_idle", 82'(in_ready0), 82'd1);
    tick();
    in_valid = 1'b0;
    in_flit  = '0;
    in_mask  = '0;
    if (v.exp_ports == 7'd0) begin
      chk("no_copy_valid", 82'(out_valid0), 82'd0);
      chk("no_copy_busy", 82'(busy0), 82'd0);
      chk("done_nocopy", 82'(done0), 82'(v.exp_done));
      tick();
      chk("done_nocopy_end", 82'(done0), 82'd0);
      chk("no_copy_valid2", 82'(out_valid0), 82'd0);
    end else begin
      first = 1'b1;
      for (int p = 0; p < 7; p++) begin
        if (v.exp_ports[p]) begin
          n = first ? v.stall : 0;
          out_ready = 1'b0;
          for (int s = 0; s < n; s++) begin
            check_copy(p, f);
            tick();
          end
          out_ready = 1'b1;
          check_copy(p, f);
          tick();
          first = 1'b0;
        end
      end
      chk("done_pulse", 82'(done0), 82'(v.exp_done));
      chk("valid_after", 82'(out_valid0), 82'd0);
      chk("in_ready_after", 82'(in_ready0), 82'd1);
      tick();
      chk("done_end", 82'(done0), 82'd0);
    end
  endtask

  initial begin
    logic [81:0] fa, fb;

    dst0 = '{{3'd7,3'd3,3'd3}, {3'd7,3'd3,3'd1}, {3'd7,3'd4,3'd2}, {3'd7,3'd2,3'd2},
             {3'd0,3'd3,3'd2}, {3'd6,3'd3,3'd2}, {3'd7,3'd3,3'd2}};
    dst1 = '{{3'd5,3'd0,3'd0}, {3'd5,3'd0,3'd6}, {3'd5,3'd1,3'd7}, {3'd5,3'd7,3'd7},
             {3'd6,3'd0,3'd7}, {3'd4,3'd0,3'd7}, {3'd5,3'd0,3'd7}};
    dst2 = '{{3'd0,3'd1,3'd0}, {3'd0,3'd1,3'd2}, {3'd0,3'd2,3'd3}, {3'd0,3'd0,3'd3},
             {3'd1,3'd1,3'd3}, {3'd3,3'd1,3'd3}, {3'd0,3'd1,3'd3}};

    //          v81   mask        payload        stall exp_ports   exp_done
    vecs[0]  = '{1'b1, 7'b0000001, 32'h0000_0001, 0, 7'b0000001, 1'b1};
    vecs[1]  = '{1'b1, 7'b0000010, 32'h0000_0002, 0, 7'b0000010, 1'b1};
    vecs[2]  = '{1'b1, 7'b0000100, 32'h0000_0004, 0, 7'b0000100, 1'b1};
    vecs[3]  = '{1'b1, 7'b0001000, 32'h0000_0008, 0, 7'b0001000, 1'b1};
    vecs[4]  = '{1'b1, 7'b0010000, 32'h0000_0010, 0, 7'b0010000, 1'b1};
    vecs[5]  = '{1'b1, 7'b0100000, 32'h0000_0020, 0, 7'b0100000, 1'b1};
    vecs[6]  = '{1'b1, 7'b1000000, 32'h0000_0040, 0, 7'b1000000, 1'b1};
    vecs[7]  = '{1'b1, 7'b0000011, 32'h3F80_0000, 0, 7'b0000011, 1'b1};
    vecs[8]  = '{1'b1, 7'b0001001, 32'hDEAD_BEEF, 0, 7'b0001001, 1'b1};
    vecs[9]  = '{1'b1, 7'b1000100, 32'hCAFE_F00D, 3, 7'b1000100, 1'b1};
    vecs[10] = '{1'b1, 7'h7F,      32'h1234_5678, 0, 7'h7F,      1'b1};
    vecs[11] = '{1'b1, 7'h00,      32'h8765_4321, 0, 7'h00,      1'b1};
    vecs[12] = '{1'b0, 7'h7F,      32'hFFFF_FFFF, 0, 7'h00,      1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 82'(in_ready0), 82'd1);
    chk("rst_out_valid", 82'(out_valid0), 82'd0);
    chk("rst_out_flit", out_flit0, 82'd0);
    chk("rst_out_port", 82'(out_port0), 82'd0);
    chk("rst_done", 82'(done0), 82'd0);
    chk("rst_busy", 82'(busy0), 82'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Back-to-back: 7-copy flit then 1-copy flit with in_valid held throughout
    fa = mk_flit(1'b1, 32'hAAAA_0001);
    fb = mk_flit(1'b1, 32'hBBBB_0002);
    in_flit   = fa;
    in_mask   = 7'h7F;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_flit = fb;
    in_mask = 7'h01;
    for (int p = 0; p < 7; p++) begin
      check_copy(p, fa);
      tick();
    end
    chk("b2b_done_a", 82'(done0), 82'd1);
    chk("b2b_ready_a", 82'(in_ready0), 82'd1);
    chk("b2b_valid_gap", 82'(out_valid0), 82'd0);
    tick();
    in_valid = 1'b0;
    in_flit  = '0;
    in_mask  = '0;
    check_copy(0, fb);
    tick();
    chk("b2b_done_b", 82'(done0), 82'd1);
    chk("b2b_valid_end", 82'(out_valid0), 82'd0);
    tick();
    chk("b2b_done_b_end", 82'(done0), 82'd0);

    // Asynchronous reset while the third copy is on offer
    fa = mk_flit(1'b1, 32'h5555_AAAA);
    in_flit   = fa;
    in_mask   = 7'h3F;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_port", 82'(out_port0), 82'd2);
    chk("pre_rst_valid", 82'(out_valid0), 82'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 82'(out_valid0), 82'd0);
    chk("arst_out_flit", out_flit0, 82'd0);
    chk("arst_out_port", 82'(out_port0), 82'd0);
    chk("arst_busy", 82'(busy0), 82'd0);
    chk("arst_in_ready", 82'(in_ready0), 82'd1);
    chk("arst_done", 82'(done0), 82'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_valid", 82'(out_valid0), 82'd0);
    chk("post_rst_done", 82'(done0), 82'd0);
    tick();
    chk("post_rst_valid2", 82'(out_valid0), 82'd0);
    run_vec(vecs[7]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
